// File: rtl/mips_pkg.sv
// Shared register-file widths and the writeback entry type.
// Used by reg_wb_queue, its storage, and the bench.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_mem.sv
// Writeback queue storage: two write ports (tail, tail+1),
// two combinational read ports (head, head+1).
module wb_queue_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 37,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [PW-1:0] wa_a,
    input  logic [W-1:0]  wd_a,
    input  logic          we_b,
    input  logic [PW-1:0] wa_b,
    input  logic [W-1:0]  wd_b,
    input  logic [PW-1:0] ra_a,
    output logic [W-1:0]  rd_a,
    input  logic [PW-1:0] ra_b,
    output logic [W-1:0]  rd_b
);

    logic [W-1:0] mem [DEPTH];

    // Port addresses are always distinct, so no write priority is needed.
    always_ff @(posedge clk) begin
        if (we_a) mem[wa_a] <= wd_a;
        if (we_b) mem[wa_b] <= wd_b;
    end

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

endmodule

// File: rtl/reg_wb_queue.sv
// Dual-lane writeback queue feeding a 2-write-port register file.
// Optional REG_WB_ZERO_FILTER_EN drops address-0 results at push.
module reg_wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in0_valid,
    input  logic [AW-1:0] in0_addr,
    input  logic [DW-1:0] in0_data,
    input  logic          in1_valid,
    input  logic [AW-1:0] in1_addr,
    input  logic [DW-1:0] in1_data,
    output logic          in_ready,
    output logic          WE1,
    output logic [AW-1:0] WA1,
    output logic [DW-1:0] WD1,
    output logic          WE2,
    output logic [AW-1:0] WA2,
    output logic [DW-1:0] WD2,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + DW;

    logic [PW-1:0] head, tail;
    logic          v0, v1;
    logic          push0, push1, pop0, pop1;
    logic [EW-1:0] wd_a, wd_b, rd_a, rd_b;
    logic [AW-1:0] hd_addr, nx_addr;

`ifdef REG_WB_ZERO_FILTER_EN
    assign v0 = in0_valid && (in0_addr != '0);
    assign v1 = in1_valid && (in1_addr != '0);
`else
    assign v0 = in0_valid;
    assign v1 = in1_valid;
`endif

    assign in_ready = Reset && (count <= CW'(DEPTH - 2));
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    // Lanes are packed: a lone in1 lands at tail, not tail+1.
    assign push0 = in_ready && (v0 || v1);
    assign push1 = in_ready && v0 && v1;
    assign wd_a  = v0 ? {in0_addr, in0_data} : {in1_addr, in1_data};
    assign wd_b  = {in1_addr, in1_data};

    assign hd_addr = rd_a[EW-1 -: AW];
    assign nx_addr = rd_b[EW-1 -: AW];

    // Same-address pair pops one at a time so the younger write wins.
    assign pop0 = (count != '0);
    assign pop1 = (count >= CW'(2)) && (nx_addr != hd_addr);

    wb_queue_mem #(
        .DEPTH(DEPTH),
        .W    (EW),
        .PW   (PW)
    ) u_mem (
        .clk (Clk),
        .we_a(push0),
        .wa_a(tail),
        .wd_a(wd_a),
        .we_b(push1),
        .wa_b(tail + PW'(1)),
        .wd_b(wd_b),
        .ra_a(head),
        .rd_a(rd_a),
        .ra_b(head + PW'(1)),
        .rd_b(rd_b)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            WE1   <= 1'b0;
            WA1   <= '0;
            WD1   <= '0;
            WE2   <= 1'b0;
            WA2   <= '0;
            WD2   <= '0;
        end else begin
            head  <= head + PW'(pop0) + PW'(pop1);
            tail  <= tail + PW'(push0) + PW'(push1);
            count <= count + CW'(push0) + CW'(push1)
                           - CW'(pop0) - CW'(pop1);
            WE1   <= pop0;
            WE2   <= pop1;
            if (pop0) begin
                WA1 <= hd_addr;
                WD1 <= rd_a[DW-1:0];
            end
            if (pop1) begin
                WA2 <= nx_addr;
                WD2 <= rd_b[DW-1:0];
            end
        end
    end

endmodule
